// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared opcodes, FSM state encoding and iteration constants
//                for the board calculator arithmetic stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Opcodes presented on the 3-bit op input
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_CAT = 3'b111;

    // Sequencer states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ITER = 1'b1;

    // Iteration count for the default 16-bit operand width
    localparam int DEF_ITER  = 16;
    localparam int ITER_LAST = DEF_ITER - 1;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module      : calc_iter_unit
//  Description : Bit-serial multiply (shift-add) and restoring divide engine.
//                One iteration per step; result presents the value the
//                registers will hold after the current step, so the caller
//                can capture it on the edge where last is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_iter_unit #(
    parameter int OP_W = 16,
    parameter int ITER = OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                is_div,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    input  logic                step,
    output logic                last,
    output logic [2*OP_W-1:0]   result
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(ITER - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    // multiply state
    logic [2*OP_W-1:0]  r_acc;
    logic [2*OP_W-1:0]  r_mcand;
    logic [OP_W-1:0]    r_mplier;
    // divide state: dividend bits shift out of r_quo MSB-first while
    // quotient bits shift in at the bottom
    logic [OP_W-1:0]    r_rem;
    logic [OP_W-1:0]    r_quo;
    logic [OP_W-1:0]    r_divisor;

    logic [2*OP_W-1:0]  w_acc_next;
    logic [OP_W:0]      w_part_rem;
    logic               w_ge;
    logic [OP_W-1:0]    w_rem_next;
    logic [OP_W-1:0]    w_quo_next;

    // Next-step datapath values for both engines
    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_part_rem = {r_rem, r_quo[OP_W-1]};
        w_ge       = (w_part_rem >= {1'b0, r_divisor});
        w_rem_next = w_ge ? OP_W'(w_part_rem - {1'b0, r_divisor}) : w_part_rem[OP_W-1:0];
        w_quo_next = {r_quo[OP_W-2:0], w_ge};
    end

    assign last   = (r_cnt == c_cnt_last);
    assign result = r_is_div ? {w_quo_next, w_rem_next} : w_acc_next;

    // Load operands on request, then advance one bit per step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
        end else if (load) begin
            r_cnt     <= '0;
            r_is_div  <= is_div;
            r_acc     <= '0;
            r_mcand   <= {{OP_W{1'b0}}, b};
            r_mplier  <= a;
            r_rem     <= '0;
            r_quo     <= a;
            r_divisor <= b;
        end else if (step) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_acc     <= w_acc_next;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_rem     <= w_rem_next;
            r_quo     <= w_quo_next;
        end
    end

endmodule : calc_iter_unit
`default_nettype wire

// File: rtl/calc_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : calc_seq_alu
//  Description : Calculator arithmetic stage. Single-cycle logic/add/sub/cat
//                ops, iterative multiply and divide, one-cycle done pulse
//                that loads the display stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int OP_W = 16,
    parameter int ITER = OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          op,
    input  logic [OP_W-1:0]     a,
    input  logic [OP_W-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*OP_W-1:0]   cal_result,
    output logic                div_by_zero
);

    logic [0:0]         r_state;
    logic               r_busy;
    logic               r_done;
    logic [2*OP_W-1:0]  r_result;
    logic               r_dbz;

    logic               w_is_iter;
    logic               w_accept;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [2*OP_W-1:0]  w_iter_result;
    logic [2*OP_W-1:0]  w_single;

    // A divide by zero is handled as a single-cycle op
    assign w_is_iter = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_load    = w_accept && w_is_iter;
    assign w_step    = (r_state == ST_ITER);

    // Single-cycle results; DIV only reaches here with b == 0
    always_comb begin
        w_single = '0;
        case (op)
            OP_ADD:  w_single = {{OP_W{1'b0}}, a} + {{OP_W{1'b0}}, b};
            OP_SUB:  w_single = {{OP_W{1'b0}}, a} - {{OP_W{1'b0}}, b};
            OP_DIV:  w_single = '1;
            OP_AND:  w_single = {{OP_W{1'b0}}, a & b};
            OP_OR:   w_single = {{OP_W{1'b0}}, a | b};
            OP_XOR:  w_single = {{OP_W{1'b0}}, a ^ b};
            OP_CAT:  w_single = {a, b};
            default: w_single = '0;
        endcase
    end

    calc_iter_unit #(
        .OP_W   (OP_W),
        .ITER   (ITER)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .step   (w_step),
        .last   (w_last),
        .result (w_iter_result)
    );

    // Sequencer: accept starts in IDLE, retire results with a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dbz <= 1'b0;
                        if (w_is_iter) begin
                            r_state <= ST_ITER;
                            r_busy  <= 1'b1;
                        end else begin
                            r_result <= w_single;
                            r_done   <= 1'b1;
                            r_dbz    <= (op == OP_DIV);
                        end
                    end
                end
                ST_ITER: begin
                    if (w_last) begin
                        r_result <= w_iter_result;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign cal_result  = r_result;
    assign div_by_zero = r_dbz;

endmodule : calc_seq_alu
`default_nettype wire

// File: tb/tb_calc_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_seq_alu
//  Description : Self-checking bench for calc_seq_alu: directed cases plus
//                randomized ops compared against an arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_seq_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] cal_result;
    logic        div_by_zero;

    int n_checks;
    int n_errors;

    calc_seq_alu #(.OP_W(16), .ITER(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .cal_result  (cal_result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    function automatic logic [31:0] ref_calc(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        longint unsigned ua = x;
        longint unsigned ub = y;
        case (o)
            3'd0: return 32'(ua + ub);
            3'd1: return 32'(ua - ub);
            3'd2: return 32'(ua * ub);
            3'd3: return (y == 0) ? 32'hFFFF_FFFF : {16'(ua / ub), 16'(ua % ub)};
            3'd4: return {16'h0, x & y};
            3'd5: return {16'h0, x | y};
            3'd6: return {16'h0, x ^ y};
            default: return {x, y};
        endcase
    endfunction

    logic [31:0] prev_result;

    // Called at a negedge. Issues one op, optionally pulses an ADD start at
    // cycle intr_at (counted from the start edge), and returns at the negedge
    // where done is observed high.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input int intr_at);
        int lat;
        int exp_lat;
        int bad_mid;
        logic [31:0] exp_res;
        exp_lat = (o == 3'd2 || (o == 3'd3 && y != 0)) ? 17 : 1;
        exp_res = ref_calc(o, x, y);
        prev_result = cal_result;
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; op = $urandom_range(0, 7); a = $urandom; b = $urandom;
        lat = 1;
        bad_mid = 0;
        while (!done && lat < 40) begin
            if (busy !== 1'b1 || cal_result !== prev_result) bad_mid++;
            if (lat == intr_at) begin
                start = 1'b1; op = 3'd0; a = 16'd1; b = 16'd1;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, cal_result, exp_res);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(o == 3'd3 && y == 0));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        if (exp_lat > 1) check({tag, "_mid"}, 32'(bad_mid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_result", cal_result, 32'h0);
        check("rst_flags", {28'h0, busy, done, div_by_zero, 1'b0}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op("add_carry", 3'd0, 16'hFFFF, 16'h0001, 0);
        check("add_val", cal_result, 32'h0001_0000);
        @(negedge clk);
        check("done_drop", 32'(done), 32'd0);

        do_op("sub", 3'd1, 16'd3, 16'd5, 0);
        check("sub_val", cal_result, 32'hFFFF_FFFE);
        // back-to-back: start while done is high
        do_op("cat", 3'd7, 16'h1234, 16'h5678, 0);
        check("cat_val", cal_result, 32'h1234_5678);

        do_op("mul_max", 3'd2, 16'hFFFF, 16'hFFFF, 0);
        check("mul_val", cal_result, 32'hFFFE_0001);
        @(negedge clk);
        check("mul_done_drop", 32'(done), 32'd0);

        do_op("div", 3'd3, 16'd100, 16'd7, 0);
        check("div_val", cal_result, 32'h000E_0002);
        do_op("div0", 3'd3, 16'd5, 16'd0, 0);
        check("div0_flag", 32'(div_by_zero), 32'd1);
        do_op("add_clr", 3'd0, 16'd2, 16'd3, 0);
        check("dbz_cleared", 32'(div_by_zero), 32'd0);

        // start during busy is ignored
        do_op("mul_ign", 3'd2, 16'd300, 16'd200, 5);
        check("mul_ign_val", cal_result, 32'h0000_EA60);
        @(negedge clk);
        check("ign_no_done", 32'(done), 32'd0);

        // reset mid-divide
        begin
            int seen_done;
            start = 1'b1; op = 3'd3; a = 16'd1000; b = 16'd3;
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_res", cal_result, 32'h0);
            seen_done = 0;
            repeat (20) begin
                if (done) seen_done++;
                @(negedge clk);
            end
            check("midrst_nodone", 32'(seen_done), 32'd0);
        end
        do_op("after_rst", 3'd0, 16'd1, 16'd1, 0);
        check("after_rst_val", cal_result, 32'h0000_0002);

        // randomized ops
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [15:0] ra;
            logic [15:0] rb;
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            do_op("rand", ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_calc_seq_alu
`default_nettype wire
